// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle M-extension unit: iterative shift-add multiply and restoring divide,
// stalling the execute stage until the result is ready.
module ex_muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_E,
  input  logic [2:0]      op_E,
  input  logic [XLEN-1:0] rd1_E,
  input  logic [XLEN-1:0] rd2_E,
  input  logic            flush_E,
  output logic            stall_E,
  output logic            done_E,
  output logic [XLEN-1:0] md_result_E
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN-1:0] a_q, b_q, hi_q;
  logic [XLEN-1:0] res_q, held_q;

  logic            accept, is_div, sa, sb, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  logic [XLEN:0]   mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0] quo_f, rem_f, fix_res;

  // Operand decode at acceptance: only signed views contribute a sign bit.
  always_comb begin
    is_div   = op_E[2];
    sa       = rd1_E[XLEN-1] & (op_E inside {3'd1, 3'd2, 3'd4, 3'd6});
    sb       = rd2_E[XLEN-1] & (op_E inside {3'd1, 3'd4, 3'd6});
    mag_a    = sa ? ('0 - rd1_E) : rd1_E;
    mag_b    = sb ? ('0 - rd2_E) : rd2_E;
    div_zero = is_div & (rd2_E == '0);
    div_ovf  = is_div & ~op_E[0] & (rd1_E == {1'b1, {(XLEN-1){1'b0}}}) & (rd2_E == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = op_E[1] ? rd1_E : '1;
    else          special_res = op_E[1] ? '0    : rd1_E;
    accept   = (state_q == IDLE) & start_E & ~flush_E;
  end

  // One iteration per cycle; a_q doubles as multiplier (shifted out LSB first)
  // and as dividend/quotient (dividend bits out of MSB, quotient bits in at LSB).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (a_q[0] ? {1'b0, b_q} : '0);
    div_trial = {hi_q, a_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, b_q};
    prod      = {hi_q, a_q};
    prod_f    = (sign_a_q ^ sign_b_q) ? ('0 - prod) : prod;
    quo_f     = (sign_a_q ^ sign_b_q) ? ('0 - a_q) : a_q;
    rem_f     = sign_a_q ? ('0 - hi_q) : hi_q;
    case (op_q)
      3'd0:                fix_res = prod_f[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_f[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_res = quo_f;
      default:             fix_res = rem_f;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (flush_E) state_d = IDLE;
            else if (cnt_q == CW'(XLEN-1)) state_d = FIX;
      FIX:  state_d = flush_E ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      res_q    <= '0;
      held_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q     <= op_E;
          sign_a_q <= sa;
          sign_b_q <= sb;
          a_q      <= mag_a;
          b_q      <= mag_b;
          hi_q     <= '0;
          cnt_q    <= '0;
          if (special) res_q <= special_res;
        end
        CALC: if (!flush_E) begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q[2]) begin
            hi_q <= div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];
            a_q  <= {a_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            hi_q <= mul_sum[XLEN:1];
            a_q  <= {mul_sum[0], a_q[XLEN-1:1]};
          end
        end
        FIX:  if (!flush_E) res_q <= fix_res;
        DONE: if (!flush_E) held_q <= res_q;
        default: ;
      endcase
    end
  end

  // The visible result switches only in an unflushed DONE cycle, so a flush there
  // leaves the previously delivered result on md_result_E.
  always_comb begin
    stall_E     = (state_q == CALC) | (state_q == FIX) |
                  ((state_q == IDLE) & start_E & ~flush_E);
    done_E      = (state_q == DONE) & ~flush_E;
    md_result_E = done_E ? res_q : held_q;
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed self-checking bench for ex_muldiv_sequencer (XLEN=32).
module tb_ex_muldiv_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_E;
  logic [2:0]      op_E;
  logic [XLEN-1:0] rd1_E, rd2_E;
  logic            flush_E;
  logic            stall_E, done_E;
  logic [XLEN-1:0] md_result_E;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] last_res = '0;

  always #5 clk = ~clk;

  ex_muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start_E(start_E), .op_E(op_E), .rd1_E(rd1_E),
    .rd2_E(rd2_E), .flush_E(flush_E), .stall_E(stall_E), .done_E(done_E),
    .md_result_E(md_result_E)
  );

  // Presents one op and holds it until done_E; latency counted in cycles after acceptance.
  task automatic do_op(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
    int lat, stall_cnt;
    bit seen;
    @(negedge clk);
    start_E = 1'b1; op_E = op; rd1_E = a; rd2_E = b;
    #1;
    stall_cnt = stall_E ? 1 : 0;
    lat = 0; seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_E) begin lat = k; seen = 1; break; end
      if (stall_E) stall_cnt++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: done_E never seen, required latency %0d", name, exp_lat);
    end else begin
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
      end
      checks++;
      if (md_result_E !== exp) begin
        errors++; $display("FAIL %s result: got %h, required %h", name, md_result_E, exp);
      end
      checks++;
      if (stall_cnt !== exp_lat) begin
        errors++; $display("FAIL %s stall cycles: got %0d, required %0d", name, stall_cnt, exp_lat);
      end
    end
    start_E = 1'b0;
    @(negedge clk);
    checks++;
    if (md_result_E !== exp || done_E !== 1'b0) begin
      errors++; $display("FAIL %s hold: result %h done %b, required %h done 0", name, md_result_E, done_E, exp);
    end
    last_res = exp;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_E = 1'b0; flush_E = 1'b0; op_E = '0; rd1_E = '0; rd2_E = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (stall_E !== 1'b0 || done_E !== 1'b0 || md_result_E !== '0) begin
      errors++; $display("FAIL reset: stall %b done %b result %h, required 0 0 0", stall_E, done_E, md_result_E);
    end
    rst = 1'b1;
  endtask

  task automatic test_mul();
    do_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    do_op("mul_zero", 3'd0, 32'h12345678, 32'h0, 32'h0, 34);
    do_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    do_op("mulhu_min", 3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    do_op("mulhsu_min", 3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 34);
    do_op("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
  endtask

  task automatic test_div();
    do_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    do_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
    do_op("div_100_m7", 3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34);
    do_op("rem_m100_7", 3'd6, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34);
    do_op("remu_big", 3'd7, 32'hFFFFFFFF, 32'h10, 32'hF, 34);
  endtask

  task automatic test_special_div();
    do_op("divu_by0", 3'd5, 32'h1234, 32'h0, 32'hFFFFFFFF, 1);
    do_op("remu_by0", 3'd7, 32'h1234, 32'h0, 32'h1234, 1);
    do_op("div_by0", 3'd4, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, 1);
    do_op("rem_by0", 3'd6, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 1);
    do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
  endtask

  task automatic test_flush();
    bit seen = 0;
    // flush arriving together with a start in IDLE drops it
    @(negedge clk);
    start_E = 1'b1; flush_E = 1'b1; op_E = 3'd0; rd1_E = 32'd3; rd2_E = 32'd5;
    #1;
    checks++;
    if (stall_E !== 1'b0) begin
      errors++; $display("FAIL flush_idle stall: got %b, required 0", stall_E);
    end
    @(negedge clk);
    start_E = 1'b0; flush_E = 1'b0;
    #1;
    checks++;
    if (stall_E !== 1'b0 || done_E !== 1'b0) begin
      errors++; $display("FAIL flush_idle state: stall %b done %b, required 0 0", stall_E, done_E);
    end
    // flush mid-multiply
    @(negedge clk);
    start_E = 1'b1; op_E = 3'd0; rd1_E = 32'd9; rd2_E = 32'd9;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    start_E = 1'b0; flush_E = 1'b1;
    @(negedge clk);
    flush_E = 1'b0;
    #1;
    checks++;
    if (stall_E !== 1'b0 || done_E !== 1'b0 || md_result_E !== last_res) begin
      errors++; $display("FAIL flush_calc: stall %b done %b result %h, required 0 0 %h",
                         stall_E, done_E, md_result_E, last_res);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_E) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_no_done: done_E pulsed after flush, required none");
    end
    do_op("after_flush", 3'd0, 32'd6, 32'd7, 32'd42, 34);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start_E = 1'b1; op_E = 3'd5; rd1_E = 32'd100; rd2_E = 32'd7;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    start_E = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (stall_E !== 1'b0 || done_E !== 1'b0 || md_result_E !== '0) begin
      errors++; $display("FAIL async_reset: stall %b done %b result %h, required 0 0 0",
                         stall_E, done_E, md_result_E);
    end
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    do_op("after_reset", 3'd5, 32'd100, 32'd7, 32'd14, 34);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 34);
    do_op("b2b_divu", 3'd5, 32'hFFFFFFFF, 32'd3, 32'h55555555, 34);
    do_op("b2b_mul", 3'd0, 32'h00010001, 32'h00010001, 32'h00020001, 34);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special_div();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
